// File: rtl/bnn_input_fetch_pkg.sv
// Shared widths, FSM encodings and a small pointer helper for the BNN input fetch path.
package bnn_input_fetch_pkg;

  localparam int BNN_DATA_W = 20;
  localparam int BNN_DEPTH  = 29;
  localparam int BNN_ADDR_W = 5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_FIN   = 2'd3;

  // Circular increment that also works for non-power-of-two depths.
  function automatic int inc_wrap(input int v, input int n);
    return (v == n - 1) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/bnn_fetch_fifo.sv
// Small synchronous FIFO holding {row, data} entries between memory read-out and the stream.
module bnn_fetch_fifo
  import bnn_input_fetch_pkg::*;
#(
  parameter int W  = 25,
  parameter int D  = 4,
  localparam int CW = $clog2(D + 1),
  localparam int PW = (D > 1) ? $clog2(D) : 1
) (
  input  logic          gclk,
  input  logic          grst_n,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  logic [W-1:0]  mem [D];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(D));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Head reads as zero when empty so the stream outputs idle at 0.
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= PW'(inc_wrap(int'(wr_ptr), D));
      if (do_pop)  rd_ptr <= PW'(inc_wrap(int'(rd_ptr), D));
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge gclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge gclk) begin
    if (grst_n && !clr && push) a_no_overflow: assert (!full);
  end

endmodule

// File: rtl/bnn_input_fetch.sv
// Reads DEPTH rows from memory port B on a start tick and streams them out in order.
module bnn_input_fetch
  import bnn_input_fetch_pkg::*;
#(
  parameter int DATA_W = BNN_DATA_W,
  parameter int DEPTH  = BNN_DEPTH,
  parameter int ADDR_W = BNN_ADDR_W,
  parameter int RD_LAT = 1,
  parameter int FIFO_D = 4
) (
  input  logic              iCLK,
  input  logic              iRSTn,
  input  logic              iCLR,
  input  logic              iSTART,
  output logic [ADDR_W-1:0] oADDR,
  output logic              oRd_EN,
  input  logic [DATA_W-1:0] iDATA,
  output logic [DATA_W-1:0] oDATA,
  output logic [ADDR_W-1:0] oROW,
  output logic              oLAST,
  output logic              oVALID,
  input  logic              iREADY,
  output logic              oBUSY,
  output logic              oDONE
);

  localparam int CW = $clog2(FIFO_D + 1);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(DEPTH - 1);

  logic [1:0]                   state, state_nx;
  logic [RD_LAT:1]              vld_pipe;
  logic [RD_LAT:1][ADDR_W-1:0]  row_pipe;
  logic [CW-1:0]                fifo_count;
  logic                         fifo_empty, fifo_full;
  logic [ADDR_W+DATA_W-1:0]     fifo_head;
  logic                         last_xfer;
  logic                         xfer;
  int                           inflight;

  always_comb begin
    inflight = 0;
    for (int i = 1; i <= RD_LAT; i++) inflight = inflight + int'(vld_pipe[i]);
  end

  // Credit counts reads still in the memory pipe, so every returning word has a slot.
  assign oRd_EN = (state == ST_FETCH) && ((int'(fifo_count) + inflight) < FIFO_D);
  assign oVALID = !fifo_empty;
  assign oDATA  = fifo_head[DATA_W-1:0];
  assign oROW   = fifo_head[DATA_W +: ADDR_W];
  assign oLAST  = (oROW == LAST_ROW);
  assign oBUSY  = (state != ST_IDLE);
  assign oDONE  = (state == ST_FIN);
  assign xfer   = oVALID && iREADY;

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (iSTART) state_nx = ST_FETCH;
      ST_FETCH: if (oRd_EN && oADDR == LAST_ROW) state_nx = ST_DRAIN;
      ST_DRAIN: if (inflight == 0 && fifo_empty && last_xfer) state_nx = ST_FIN;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state     <= ST_IDLE;
      oADDR     <= '0;
      vld_pipe  <= '0;
      row_pipe  <= '0;
      last_xfer <= 1'b0;
    end else if (iCLR) begin
      state     <= ST_IDLE;
      oADDR     <= '0;
      vld_pipe  <= '0;
      row_pipe  <= '0;
      last_xfer <= 1'b0;
    end else begin
      state       <= state_nx;
      vld_pipe[1] <= oRd_EN;
      row_pipe[1] <= oADDR;
      for (int i = 2; i <= RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        row_pipe[i] <= row_pipe[i-1];
      end
      if (oRd_EN) begin
        if (oADDR != LAST_ROW) oADDR <= oADDR + 1'b1;
      end else if (state == ST_IDLE || state == ST_FIN) begin
        oADDR <= '0;
      end
      if (state == ST_IDLE)  last_xfer <= 1'b0;
      else if (xfer && oLAST) last_xfer <= 1'b1;
    end
  end

  bnn_fetch_fifo #(.W(ADDR_W + DATA_W), .D(FIFO_D)) u_fifo (
    .gclk   (iCLK),
    .grst_n (iRSTn),
    .clr    (iCLR),
    .push   (vld_pipe[RD_LAT]),
    .pop    (iREADY),
    .din    ({row_pipe[RD_LAT], iDATA}),
    .dout   (fifo_head),
    .count  (fifo_count),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

endmodule

// File: tb/tb_bnn_input_fetch.sv
// Directed + randomized bench for bnn_input_fetch, RD_LAT=1 and RD_LAT=2 builds side by side.
module tb_bnn_input_fetch;
  localparam int DW  = 20;
  localparam int AW  = 5;
  localparam int DEP = 29;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, clr, start, ready;
  logic [AW-1:0] addr1, addr2, row1, row2;
  logic          rd1, rd2, v1, v2, l1, l2, b1, b2, dn1, dn2;
  logic [DW-1:0] q1, q2a, q2b, d1, d2;
  logic [DW-1:0] mem [0:31];

  // Memory models: one-cycle and two-cycle read latency.
  always @(posedge clk) if (rd1) q1 <= mem[addr1];
  always @(posedge clk) begin
    if (rd2) q2a <= mem[addr2];
    q2b <= q2a;
  end

  bnn_input_fetch #(.RD_LAT(1)) u1 (
    .iCLK(clk), .iRSTn(rst_n), .iCLR(clr), .iSTART(start), .oADDR(addr1), .oRd_EN(rd1),
    .iDATA(q1), .oDATA(d1), .oROW(row1), .oLAST(l1), .oVALID(v1), .iREADY(ready),
    .oBUSY(b1), .oDONE(dn1));

  bnn_input_fetch #(.RD_LAT(2)) u2 (
    .iCLK(clk), .iRSTn(rst_n), .iCLR(clr), .iSTART(start), .oADDR(addr2), .oRd_EN(rd2),
    .iDATA(q2b), .oDATA(d2), .oROW(row2), .oLAST(l2), .oVALID(v2), .iREADY(ready),
    .oBUSY(b2), .oDONE(dn2));

  logic          sel;
  logic [AW-1:0] s_addr, s_row;
  logic [DW-1:0] s_d;
  logic          s_rd, s_v, s_l, s_b, s_dn;
  assign s_addr = sel ? addr2 : addr1;
  assign s_row  = sel ? row2  : row1;
  assign s_d    = sel ? d2    : d1;
  assign s_rd   = sel ? rd2   : rd1;
  assign s_v    = sel ? v2    : v1;
  assign s_l    = sel ? l2    : l1;
  assign s_b    = sel ? b2    : b1;
  assign s_dn   = sel ? dn2   : dn1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // rmode: 0 ready high, 1 random ready, 2 ready low for the first 50 cycles.
  task automatic run_frame(input int rmode, input int start_row, input int clr_row);
    int lat, exp_row, issued, ndone, first_v, done_k, stray;
    logic [DW-1:0] prev_d;
    logic [AW-1:0] prev_r;
    bit stall, injected, pend_clr, finished;
    lat = sel ? 2 : 1;
    exp_row = 0; issued = 0; ndone = 0; first_v = -1; done_k = -1; stray = 0;
    stall = 0; injected = 0; pend_clr = 0; finished = 0;
    prev_d = '0; prev_r = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 400 && !finished; k++) begin
      if (pend_clr) begin
        clr = 1'b0;
        chk("clr_valid", s_v, 0);
        chk("clr_busy", s_b, 0);
        chk("clr_addr", s_addr, 0);
        chk("clr_done", s_dn, 0);
        ready = 1'b1;
        for (int j = 0; j < 40; j++) begin
          @(negedge clk);
          if (s_dn || s_v || s_b) stray++;
        end
        chk("clr_quiet", stray, 0);
        return;
      end
      if (done_k >= 0 && k == done_k + 1) begin
        chk("post_busy", s_b, 0);
        chk("post_valid", s_v, 0);
        finished = 1;
      end else begin
        chk("busy", s_b, 1);
      end
      if (!finished) begin
        if (s_v) begin
          if (first_v < 0) first_v = k;
          chk("row", s_row, exp_row);
          chk("data", s_d, mem[exp_row]);
          chk("last", s_l, exp_row == DEP - 1);
          if (stall) begin
            chk("stall_data", s_d, prev_d);
            chk("stall_row", s_row, prev_r);
          end
        end
        if (s_rd) begin
          chk("rd_addr", s_addr, issued);
          chk("credit", (issued - exp_row) < 4, 1);
          issued++;
        end
        if (s_dn) begin
          ndone++;
          done_k = k;
          chk("done_rows", exp_row, DEP);
        end
        if (rmode == 2 && k == 50) begin
          chk("hold_issued", issued, 4);
          chk("hold_valid", s_v, 1);
          chk("hold_row", s_row, 0);
        end
        case (rmode)
          0:       ready = 1'b1;
          1:       ready = 1'($urandom_range(0, 1));
          default: ready = (k >= 50);
        endcase
        if (clr_row >= 0 && s_v && s_row == AW'(clr_row)) begin
          clr = 1'b1;
          ready = 1'b0;
          pend_clr = 1;
        end
        if (start_row >= 0 && !injected && s_v && s_row == AW'(start_row)) begin
          start = 1'b1;
          injected = 1;
        end
        stall  = s_v && !ready;
        prev_d = s_d;
        prev_r = s_row;
        if (s_v && ready) exp_row++;
        @(negedge clk);
        start = 1'b0;
      end
    end
    chk("ndone", ndone, 1);
    chk("rows", exp_row, DEP);
    if (rmode == 0) begin
      chk("first_valid", first_v, lat + 2);
      chk("done_cycle", done_k, lat + 32);
    end
    ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      if (s_dn || s_b) stray++;
    end
    chk("idle_after", stray, 0);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; start = 1'b0; ready = 1'b0; sel = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = DW'(32'h100 + i);
    #12;
    chk("rst_valid", v1, 0);
    chk("rst_busy", b1, 0);
    chk("rst_done", dn1, 0);
    chk("rst_rden", rd1, 0);
    chk("rst_addr", addr1, 0);
    chk("rst_data", d1, 0);
    chk("rst_row", row1, 0);
    chk("rst_last", l1, 0);
    chk("rst_valid2", v2, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);

    run_frame(0, -1, -1);               // streaming, ready high
    void'($urandom(7));
    run_frame(1, -1, -1);               // random back-pressure
    run_frame(2, -1, -1);               // long stall
    run_frame(0, 10, -1);               // second start ignored
    run_frame(0, -1, 15);               // clear mid-frame
    run_frame(0, -1, -1);               // frame after clear
    sel = 1'b1;
    run_frame(0, -1, -1);               // RD_LAT=2 timing
    for (int i = 0; i < 32; i++) mem[i] = DW'($urandom);
    sel = 1'b0;
    run_frame(1, -1, -1);
    sel = 1'b1;
    run_frame(1, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
